clock_input_conditioner: RTL and testbench



---
 rtl/clock_input_conditioner_pkg.sv | 16 +
 rtl/clock_input_conditioner_if.sv | 24 ++
 rtl/clock_input_conditioner_sync_debounce.sv | 55 +++++
 rtl/clock_input_conditioner.sv | 145 ++++++++++++++
 tb/tb_clock_input_conditioner.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/clock_input_conditioner_pkg.sv
// Shared types and default timing constants for the clock UI front end.
// Defaults assume a 50 MHz board clock.
package clock_ui_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESSED = 2'b01,
    REPEAT  = 2'b10
  } inc_state_e;

  localparam int unsigned DEF_TICK_DIV      = 32'd50000000;
  localparam int unsigned DEF_DB_CYCLES     = 32'd1000000;
  localparam int unsigned DEF_HOLD_CYCLES   = 32'd25000000;
  localparam int unsigned DEF_REPEAT_CYCLES = 32'd10000000;

endpackage

// File: rtl/clock_input_conditioner_if.sv
// Board-side raw inputs and conditioned outputs of the clock input conditioner.
// master drives the raw buttons/switch; slave is the conditioner itself.
interface clock_input_conditioner_if;

  logic set_raw;
  logic inc_raw;
  logic cen_raw;
  logic set_pulse;
  logic inc_pulse;
  logic cen_level;
  logic tick_1hz;
  logic blink;

  modport master (
    output set_raw, inc_raw, cen_raw,
    input  set_pulse, inc_pulse, cen_level, tick_1hz, blink
  );

  modport slave (
    input  set_raw, inc_raw, cen_raw,
    output set_pulse, inc_pulse, cen_level, tick_1hz, blink
  );

endinterface

// File: rtl/clock_input_conditioner_sync_debounce.sv
// Two-flop synchroniser followed by a stability counter; deb follows sync only
// after DB_CYCLES consecutive samples that differ from the current level.
module sync_debounce
  import clock_ui_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  localparam int unsigned CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 32'd1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/clock_input_conditioner.sv
// Conditions raw set/inc/cen inputs into clean pulses/levels, adds inc
// auto-repeat, and generates the seconds tick and display blink level.
module clock_input_conditioner
  import clock_ui_pkg::*;
#(
  parameter int unsigned TICK_DIV      = DEF_TICK_DIV,
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  clock_input_conditioner_if.slave   io
);

  localparam int unsigned PW  = $clog2(TICK_DIV);
  localparam int unsigned HW  = $clog2(HOLD_CYCLES);
  localparam int unsigned RPW = $clog2(REPEAT_CYCLES);
  localparam int unsigned RW  = (HW > RPW) ? HW : RPW;

  localparam logic [PW-1:0] TICK_LAST   = PW'(TICK_DIV - 32'd1);
  localparam logic [PW-1:0] TICK_HALF   = PW'(TICK_DIV / 32'd2 - 32'd1);
  localparam logic [RW-1:0] HOLD_LAST   = RW'(HOLD_CYCLES - 32'd1);
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CYCLES - 32'd1);

  logic deb_set, deb_inc, deb_cen;
  logic set_rise, inc_rise;

  logic          set_prev_q, set_prev_d;
  logic          inc_prev_q, inc_prev_d;
  logic          set_pulse_q, set_pulse_d;
  logic          inc_pulse_q, inc_pulse_d;
  inc_state_e    inc_state_q, inc_state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          tick_q, tick_d;
  logic          blink_q, blink_d;

  sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk(clk), .rst(rst), .raw(io.set_raw), .deb(deb_set)
  );
  sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .clk(clk), .rst(rst), .raw(io.inc_raw), .deb(deb_inc)
  );
  sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_cen (
    .clk(clk), .rst(rst), .raw(io.cen_raw), .deb(deb_cen)
  );

  assign set_rise = deb_set & ~set_prev_q;
  assign inc_rise = deb_inc & ~inc_prev_q;

  // Release wins over a repeat pulse that would fall on the same cycle.
  always_comb begin
    set_prev_d  = deb_set;
    inc_prev_d  = deb_inc;
    set_pulse_d = set_rise;
    inc_pulse_d = 1'b0;
    inc_state_d = inc_state_q;
    rcnt_d      = rcnt_q;
    case (inc_state_q)
      IDLE: begin
        rcnt_d = '0;
        if (inc_rise) begin
          inc_pulse_d = 1'b1;
          inc_state_d = PRESSED;
        end else begin
          inc_state_d = IDLE;
        end
      end
      PRESSED: begin
        if (!deb_inc) begin
          inc_state_d = IDLE;
          rcnt_d      = '0;
        end else if (rcnt_q == HOLD_LAST) begin
          inc_pulse_d = 1'b1;
          inc_state_d = REPEAT;
          rcnt_d      = '0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      REPEAT: begin
        if (!deb_inc) begin
          inc_state_d = IDLE;
          rcnt_d      = '0;
        end else if (rcnt_q == REPEAT_LAST) begin
          inc_pulse_d = 1'b1;
          rcnt_d      = '0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      default: begin
        inc_state_d = IDLE;
        rcnt_d      = '0;
      end
    endcase
  end

  always_comb begin
    tick_d  = 1'b0;
    blink_d = blink_q;
    if (pcnt_q == TICK_LAST) begin
      pcnt_d  = '0;
      tick_d  = 1'b1;
      blink_d = ~blink_q;
    end else if (pcnt_q == TICK_HALF) begin
      pcnt_d  = pcnt_q + PW'(1);
      blink_d = ~blink_q;
    end else begin
      pcnt_d = pcnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_prev_q  <= 1'b0;
      inc_prev_q  <= 1'b0;
      set_pulse_q <= 1'b0;
      inc_pulse_q <= 1'b0;
      inc_state_q <= IDLE;
      rcnt_q      <= '0;
      pcnt_q      <= '0;
      tick_q      <= 1'b0;
      blink_q     <= 1'b0;
    end else begin
      set_prev_q  <= set_prev_d;
      inc_prev_q  <= inc_prev_d;
      set_pulse_q <= set_pulse_d;
      inc_pulse_q <= inc_pulse_d;
      inc_state_q <= inc_state_d;
      rcnt_q      <= rcnt_d;
      pcnt_q      <= pcnt_d;
      tick_q      <= tick_d;
      blink_q     <= blink_d;
    end
  end

  assign io.set_pulse = set_pulse_q;
  assign io.inc_pulse = inc_pulse_q;
  assign io.cen_level = deb_cen;
  assign io.tick_1hz  = tick_q;
  assign io.blink     = blink_q;

endmodule

// File: tb/tb_clock_input_conditioner.sv
// Directed bench for clock_input_conditioner with small timing parameters;
// cycle c means the state sampled 1 time unit after the c-th edge past reset.
module tb_clock_input_conditioner;
  import clock_ui_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  clock_input_conditioner_if bus ();

  clock_input_conditioner #(
    .TICK_DIV(10), .DB_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " set_pulse"}, {1'b0, bus.set_pulse}, 2'd0);
    check({tag, " inc_pulse"}, {1'b0, bus.inc_pulse}, 2'd0);
    check({tag, " cen_level"}, {1'b0, bus.cen_level}, 2'd0);
    check({tag, " tick_1hz"},  {1'b0, bus.tick_1hz},  2'd0);
    check({tag, " blink"},     {1'b0, bus.blink},     2'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.set_raw = 1'b0;
    bus.inc_raw = 1'b0;
    bus.cen_raw = 1'b0;
    step();
    step();
    check_outputs_zero("reset");
    check("reset state", dut.inc_state_q, IDLE);
    rst = 1'b0;
  endtask

  function automatic logic inc_exp(input int c);
    return (c == 7) || (c == 27) || (c == 32) || (c == 37) || (c == 42) || (c == 47);
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.set_raw = 1'b0;
    bus.inc_raw = 1'b0;
    bus.cen_raw = 1'b0;

    // Idle prescaler: ticks at 10/20/30, blink toggles every 5 cycles.
    do_reset();
    for (int c = 1; c <= 35; c++) begin
      step();
      check($sformatf("tick c%0d", c), {1'b0, bus.tick_1hz}, {1'b0, c % 10 == 0});
      check($sformatf("blink c%0d", c), {1'b0, bus.blink}, {1'b0, (c / 5) % 2 == 1});
      check($sformatf("idle set c%0d", c), {1'b0, bus.set_pulse}, 2'd0);
      check($sformatf("idle inc c%0d", c), {1'b0, bus.inc_pulse}, 2'd0);
    end

    // Held set: single pulse at cycle 7, nothing on release.
    do_reset();
    bus.set_raw = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      check($sformatf("set hold c%0d", c), {1'b0, bus.set_pulse}, {1'b0, c == 7});
    end
    bus.set_raw = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      step();
      check($sformatf("set release c%0d", c), {1'b0, bus.set_pulse}, 2'd0);
    end

    // Held inc: first pulse, hold pulse, repeats; the would-be pulse at 52
    // coincides with release and must be suppressed.
    do_reset();
    bus.inc_raw = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      step();
      check($sformatf("inc c%0d", c), {1'b0, bus.inc_pulse}, {1'b0, inc_exp(c)});
      if (c == 45) bus.inc_raw = 1'b0;
    end
    check("inc state after release", dut.inc_state_q, IDLE);

    // Glitches of 1..3 cycles on set are rejected.
    do_reset();
    for (int w = 1; w <= 3; w++) begin
      bus.set_raw = 1'b1;
      for (int k = 0; k < w; k++) begin
        step();
        check($sformatf("glitch w%0d hi%0d", w, k), {1'b0, bus.set_pulse}, 2'd0);
      end
      bus.set_raw = 1'b0;
      for (int k = 0; k < 5; k++) begin
        step();
        check($sformatf("glitch w%0d lo%0d", w, k), {1'b0, bus.set_pulse}, 2'd0);
      end
    end
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("glitch tail %0d", k), {1'b0, bus.set_pulse}, 2'd0);
    end

    // cen level follows 6 cycles after each raw change.
    bus.cen_raw = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      check($sformatf("cen rise c%0d", c), {1'b0, bus.cen_level}, {1'b0, c >= 6});
    end
    bus.cen_raw = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      check($sformatf("cen fall c%0d", c), {1'b0, bus.cen_level}, {1'b0, c < 6});
    end

    // Simultaneous set and inc.
    do_reset();
    bus.set_raw = 1'b1;
    bus.inc_raw = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      check($sformatf("both set c%0d", c), {1'b0, bus.set_pulse}, {1'b0, c == 7});
      check($sformatf("both inc c%0d", c), {1'b0, bus.inc_pulse}, {1'b0, c == 7});
    end

    // Reset mid-repeat with inc still held.
    do_reset();
    bus.inc_raw = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      step();
      check($sformatf("pre-rst inc c%0d", c), {1'b0, bus.inc_pulse},
            {1'b0, c == 7 || c == 27 || c == 32});
    end
    check("pre-rst state", dut.inc_state_q, REPEAT);
    rst = 1'b1;
    #1;
    check_outputs_zero("async rst");
    check("async rst state", dut.inc_state_q, IDLE);
    @(posedge clk);
    step();
    rst = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      step();
      check($sformatf("post-rst inc c%0d", c), {1'b0, bus.inc_pulse},
            {1'b0, c == 7 || c == 27});
      if (c == 8) check("post-rst state", dut.inc_state_q, PRESSED);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
